// File: rtl/genius_datapath_pkg.sv
// Shared constants and types for the Genius responder datapath.
package genius_datapath_pkg;

   localparam int         ADDR_WIDTH = 6;
   localparam int         DEPTH      = 64;
   localparam logic [7:0] LFSR_SEED  = 8'hA5;

   typedef enum logic {
      LED_IDLE = 1'b0,
      LED_SHOW = 1'b1
   } led_state_t;

   function automatic logic [3:0] onehot4(input logic [1:0] sel);
      onehot4 = 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); low two bits pick a random colour.
module genius_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [1:0] rnd
);

   logic [7:0] state_r;

   // Shift left, feedback from taps 8,6,5,4; a nonzero seed keeps it off the all-zero lockup state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= SEED;
      end else if (en) begin
         state_r <= {state_r[6:0], state_r[7] ^ state_r[5] ^ state_r[4] ^ state_r[3]};
      end
   end

   assign rnd = state_r[1:0];

endmodule

// File: rtl/genius_datapath.sv
// Genius responder datapath: settings, sequence memory, index counters, score and LED display timer.
module genius_datapath
   import genius_datapath_pkg::*;
#(
   parameter int DATA_WIDTH  = 4,
   parameter int DIFF_WIDTH  = 2,
   parameter int SCORE_WIDTH = 8,
   parameter int T_FAST      = 25,
   parameter int T_SLOW      = 50
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_WIDTH-1:0]  player_input,
   input  logic [DIFF_WIDTH-1:0]  difficulty,
   input  logic                   speed,
   input  logic                   mode,
   input  logic                   settings_wr,
   input  logic                   player_wr,
   input  logic                   mem_rd,
   input  logic                   mem_wr,
   input  logic                   inc_match_index,
   input  logic                   inc_sequence_index,
   input  logic                   inc_score,
   input  logic                   rst_match,
   input  logic                   rst_sequence,
   input  logic                   rst_score,
   input  logic                   update_score,
   input  logic                   enable_led,
   input  logic                   all_leds,
   output logic [DATA_WIDTH-1:0]  sequence_item,
   output logic [ADDR_WIDTH-1:0]  match_index,
   output logic [ADDR_WIDTH-1:0]  sequence_index,
   output logic [ADDR_WIDTH:0]    seq_limit,
   output logic [SCORE_WIDTH-1:0] score,
   output logic [SCORE_WIDTH-1:0] best_score,
   output logic [DATA_WIDTH-1:0]  leds,
   output logic                   led_busy
);

   localparam int TW = $clog2(((T_SLOW > T_FAST) ? T_SLOW : T_FAST) + 1);
   localparam logic [ADDR_WIDTH-1:0] IDX_MAX = ADDR_WIDTH'(DEPTH - 1);

   logic [DIFF_WIDTH-1:0]  difficulty_r;
   logic                   speed_r;
   logic                   mode_r;
   logic [ADDR_WIDTH:0]    seq_limit_r;
   logic [DATA_WIDTH-1:0]  player_r;
   logic [1:0]             rnd_s;
   logic [DATA_WIDTH-1:0]  wdata_s;
   logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
   logic [DATA_WIDTH-1:0]  item_r;
   logic [ADDR_WIDTH-1:0]  match_r;
   logic [ADDR_WIDTH-1:0]  seq_r;
   logic [SCORE_WIDTH-1:0] score_r;
   logic [SCORE_WIDTH-1:0] best_r;
   led_state_t             led_state_r;
   logic [TW-1:0]          timer_r;
   logic [DATA_WIDTH-1:0]  leds_r;
   logic                   busy_r;

   genius_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .rnd   (rnd_s)
   );

   // Settings capture; the sequence limit is registered alongside difficulty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         difficulty_r <= {DIFF_WIDTH{1'b0}};
         speed_r      <= 1'b0;
         mode_r       <= 1'b0;
         seq_limit_r  <= {(ADDR_WIDTH+1){1'b0}};
      end else if (settings_wr) begin
         difficulty_r <= difficulty;
         speed_r      <= speed;
         mode_r       <= mode;
         seq_limit_r  <= (ADDR_WIDTH+1)'(8) << difficulty;
      end
   end

   // Latch a button press; an all-zero sample is treated as no press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         player_r <= {DATA_WIDTH{1'b0}};
      end else if (player_wr && (player_input != {DATA_WIDTH{1'b0}})) begin
         player_r <= player_input;
      end
   end

   // Write data: echoed player colour in mode 1, random one-hot colour otherwise
   always_comb begin
      wdata_s = {DATA_WIDTH{1'b0}};
      if (mode_r) begin
         wdata_s = player_r;
      end else begin
         wdata_s = DATA_WIDTH'(onehot4(rnd_s));
      end
   end

   // Sequence storage, intentionally without reset
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem_r[seq_r] <= wdata_s;
      end
   end

   // Registered read port; same-address write in the same cycle returns the old word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         item_r <= {DATA_WIDTH{1'b0}};
      end else if (mem_rd) begin
         item_r <= mem_r[match_r];
      end
   end

   // Player position counter, clear wins over increment, saturates at DEPTH-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_r <= {ADDR_WIDTH{1'b0}};
      end else if (rst_match) begin
         match_r <= {ADDR_WIDTH{1'b0}};
      end else if (inc_match_index && (match_r != IDX_MAX)) begin
         match_r <= match_r + ADDR_WIDTH'(1);
      end
   end

   // Sequence length counter, same clear/saturate rules
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_r <= {ADDR_WIDTH{1'b0}};
      end else if (rst_sequence) begin
         seq_r <= {ADDR_WIDTH{1'b0}};
      end else if (inc_sequence_index && (seq_r != IDX_MAX)) begin
         seq_r <= seq_r + ADDR_WIDTH'(1);
      end
   end

   // Score counter saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_r <= {SCORE_WIDTH{1'b0}};
      end else if (rst_score) begin
         score_r <= {SCORE_WIDTH{1'b0}};
      end else if (inc_score && (score_r != {SCORE_WIDTH{1'b1}})) begin
         score_r <= score_r + SCORE_WIDTH'(1);
      end
   end

   // Best score compares against the pre-increment score
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_r <= {SCORE_WIDTH{1'b0}};
      end else if (update_score && (score_r > best_r)) begin
         best_r <= score_r;
      end
   end

   // LED display timer; a request while showing is dropped rather than restarting the hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_state_r <= LED_IDLE;
         timer_r     <= {TW{1'b0}};
         leds_r      <= {DATA_WIDTH{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         case (led_state_r)
            LED_IDLE: begin
               if (enable_led) begin
                  led_state_r <= LED_SHOW;
                  timer_r     <= speed_r ? TW'(T_FAST) : TW'(T_SLOW);
                  leds_r      <= item_r;
                  busy_r      <= 1'b1;
               end
            end
            LED_SHOW: begin
               if (timer_r == TW'(1)) begin
                  led_state_r <= LED_IDLE;
                  timer_r     <= {TW{1'b0}};
                  leds_r      <= {DATA_WIDTH{1'b0}};
                  busy_r      <= 1'b0;
               end else begin
                  timer_r <= timer_r - TW'(1);
               end
            end
            default: begin
               led_state_r <= LED_IDLE;
               timer_r     <= {TW{1'b0}};
               leds_r      <= {DATA_WIDTH{1'b0}};
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign sequence_item  = item_r;
   assign match_index    = match_r;
   assign sequence_index = seq_r;
   assign seq_limit      = seq_limit_r;
   assign score          = score_r;
   assign best_score     = best_r;
   assign leds           = all_leds ? {DATA_WIDTH{1'b1}} : leds_r;
   assign led_busy       = busy_r;

endmodule

// File: tb/tb_genius_datapath.sv
// Scoreboard bench for genius_datapath: stimulus queues expected values, a negedge monitor checks them.
module tb_genius_datapath;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] player_input;
   logic [1:0] difficulty;
   logic       speed, mode, settings_wr, player_wr, mem_rd, mem_wr;
   logic       inc_match_index, inc_sequence_index, inc_score;
   logic       rst_match, rst_sequence, rst_score;
   logic       update_score, enable_led, all_leds;
   logic [3:0] sequence_item;
   logic [5:0] match_index, sequence_index;
   logic [6:0] seq_limit;
   logic [7:0] score, best_score;
   logic [3:0] leds;
   logic       led_busy;

   genius_datapath dut (
      .clk(clk), .rst_n(rst_n), .player_input(player_input), .difficulty(difficulty),
      .speed(speed), .mode(mode), .settings_wr(settings_wr), .player_wr(player_wr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .inc_match_index(inc_match_index),
      .inc_sequence_index(inc_sequence_index), .inc_score(inc_score),
      .rst_match(rst_match), .rst_sequence(rst_sequence), .rst_score(rst_score),
      .update_score(update_score), .enable_led(enable_led), .all_leds(all_leds),
      .sequence_item(sequence_item), .match_index(match_index),
      .sequence_index(sequence_index), .seq_limit(seq_limit), .score(score),
      .best_score(best_score), .leds(leds), .led_busy(led_busy)
   );

   always #5 clk = ~clk;

   localparam int S_ITEM = 0, S_MATCH = 1, S_SEQ = 2, S_LIMIT = 3, S_SCORE = 4,
                  S_BEST = 5, S_LEDS = 6, S_BUSY = 7, S_LFSR = 8;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      int          when;
      string       name;
   } sb_t;

   sb_t  sb_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] m_lfsr;
   logic [3:0] exp_item;
   logic [7:0] m;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      lfsr_next = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Reference LFSR used to predict random colours written in mode 0
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 8'hA5;
      else        m_lfsr <= lfsr_next(m_lfsr);
   end

   function automatic logic [31:0] get_out(input int sel);
      case (sel)
         S_ITEM:  get_out = 32'(sequence_item);
         S_MATCH: get_out = 32'(match_index);
         S_SEQ:   get_out = 32'(sequence_index);
         S_LIMIT: get_out = 32'(seq_limit);
         S_SCORE: get_out = 32'(score);
         S_BEST:  get_out = 32'(best_score);
         S_LEDS:  get_out = 32'(leds);
         S_BUSY:  get_out = 32'(led_busy);
         S_LFSR:  get_out = 32'(dut.u_lfsr.state_r);
         default: get_out = 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: compare every expectation due this cycle, away from the active edge
   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].when == cyc) begin
            logic [31:0] act;
            act = get_out(sb_q[i].sel);
            checks++;
            if (act !== sb_q[i].exp) begin
               failures++;
               $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h",
                        sb_q[i].name, cyc, act, sb_q[i].exp);
            end
            sb_q.delete(i);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input int sel, input logic [31:0] v, input int dly, input string name);
      sb_q.push_back('{sel: sel, exp: v, when: cyc + dly, name: name});
   endtask

   task automatic set_cfg(input logic [1:0] d, input logic s, input logic md);
      difficulty = d; speed = s; mode = md; settings_wr = 1'b1;
      step(1);
      settings_wr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; player_input = 4'd0; difficulty = 2'd0; speed = 1'b0; mode = 1'b0;
      settings_wr = 1'b0; player_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      inc_match_index = 1'b0; inc_sequence_index = 1'b0; inc_score = 1'b0;
      rst_match = 1'b0; rst_sequence = 1'b0; rst_score = 1'b0;
      update_score = 1'b0; enable_led = 1'b0; all_leds = 1'b0;
      step(3);

      // Reset values and the full LFSR period
      for (int s = 0; s < 8; s++) sb_push(s, 32'd0, 0, "reset_out");
      sb_push(S_LFSR, 32'hA5, 0, "lfsr_seed");
      rst_n = 1'b1;
      m = 8'hA5;
      for (int k = 1; k <= 255; k++) begin
         m = lfsr_next(m);
         if (k == 255) sb_push(S_LFSR, 32'hA5, k, "lfsr_period");
         else          sb_push(S_LFSR, 32'(m), k, "lfsr_seq");
      end
      step(256);

      // Settings, player latch (zero ignored), write/read in mode 1
      set_cfg(2'd2, 1'b1, 1'b1);
      sb_push(S_LIMIT, 32'd32, 0, "seq_limit_d2");
      player_input = 4'b0100; player_wr = 1'b1; step(1);
      player_input = 4'b0000; step(1); player_wr = 1'b0;
      mem_wr = 1'b1; step(1); mem_wr = 1'b0;
      mem_rd = 1'b1; step(1); mem_rd = 1'b0;
      sb_push(S_ITEM, 32'h4, 0, "mem_rd_idx0");
      step(2);
      sb_push(S_ITEM, 32'h4, 0, "item_held");

      // Read-before-write on a shared address
      inc_sequence_index = 1'b1; inc_match_index = 1'b1;
      player_input = 4'b1000; player_wr = 1'b1; step(1);
      inc_sequence_index = 1'b0; inc_match_index = 1'b0; player_wr = 1'b0;
      sb_push(S_SEQ, 32'd1, 0, "seq_idx_1"); sb_push(S_MATCH, 32'd1, 0, "match_idx_1");
      mem_wr = 1'b1; step(1); mem_wr = 1'b0;
      mem_rd = 1'b1; step(1); mem_rd = 1'b0;
      sb_push(S_ITEM, 32'h8, 0, "mem_rd_idx1");
      player_input = 4'b0010; player_wr = 1'b1; step(1); player_wr = 1'b0; player_input = 4'b0000;
      mem_wr = 1'b1; mem_rd = 1'b1; step(1); mem_wr = 1'b0; mem_rd = 1'b0;
      sb_push(S_ITEM, 32'h8, 0, "rbw_old");
      mem_rd = 1'b1; step(1); mem_rd = 1'b0;
      sb_push(S_ITEM, 32'h2, 0, "rbw_new");

      // Mode 0 writes a random one-hot colour
      set_cfg(2'd3, 1'b1, 1'b0);
      sb_push(S_LIMIT, 32'd64, 0, "seq_limit_d3");
      inc_sequence_index = 1'b1; inc_match_index = 1'b1; step(1);
      inc_sequence_index = 1'b0; inc_match_index = 1'b0;
      exp_item = 4'b0001 << m_lfsr[1:0];
      mem_wr = 1'b1; step(1); mem_wr = 1'b0;
      mem_rd = 1'b1; step(1); mem_rd = 1'b0;
      sb_push(S_ITEM, 32'(exp_item), 0, "mem_lfsr_item");

      // Fast LED hold, with an ignored re-trigger mid-show
      rst_match = 1'b1; step(1); rst_match = 1'b0;
      sb_push(S_MATCH, 32'd0, 0, "match_rst");
      mem_rd = 1'b1; step(1); mem_rd = 1'b0;
      sb_push(S_ITEM, 32'h4, 0, "item_idx0");
      set_cfg(2'd2, 1'b1, 1'b0);
      enable_led = 1'b1; step(1); enable_led = 1'b0;
      sb_push(S_LEDS, 32'h4, 0, "led_on");   sb_push(S_BUSY, 32'd1, 0, "busy_on");
      sb_push(S_LEDS, 32'h4, 24, "led_24");  sb_push(S_BUSY, 32'd1, 24, "busy_24");
      sb_push(S_LEDS, 32'h0, 25, "led_off"); sb_push(S_BUSY, 32'd0, 25, "busy_off");
      step(4); enable_led = 1'b1; step(1); enable_led = 1'b0;
      step(21);

      // all_leds override during SHOW
      enable_led = 1'b1; step(1); enable_led = 1'b0;
      sb_push(S_LEDS, 32'h4, 0, "led_on2");
      step(3); all_leds = 1'b1;
      sb_push(S_LEDS, 32'hF, 0, "all_leds_show");
      step(2); all_leds = 1'b0;
      sb_push(S_LEDS, 32'h4, 0, "all_leds_drop"); sb_push(S_BUSY, 32'd1, 0, "busy_all");
      sb_push(S_LEDS, 32'h4, 19, "led_24b");      sb_push(S_LEDS, 32'h0, 20, "led_off2");
      step(21);

      // Slow LED hold
      set_cfg(2'd1, 1'b0, 1'b0);
      sb_push(S_LIMIT, 32'd16, 0, "seq_limit_d1");
      enable_led = 1'b1; step(1); enable_led = 1'b0;
      sb_push(S_LEDS, 32'h4, 49, "led_slow_49");
      sb_push(S_LEDS, 32'h0, 50, "led_slow_off"); sb_push(S_BUSY, 32'd0, 50, "busy_slow_off");
      step(51);
      all_leds = 1'b1;
      sb_push(S_LEDS, 32'hF, 0, "all_leds_idle");
      step(1); all_leds = 1'b0;

      // Counter saturation and clear-beats-increment
      rst_sequence = 1'b1; step(1); rst_sequence = 1'b0;
      sb_push(S_SEQ, 32'd0, 0, "seq_rst");
      inc_sequence_index = 1'b1;
      sb_push(S_SEQ, 32'd62, 62, "seq_62"); sb_push(S_SEQ, 32'd63, 63, "seq_63");
      sb_push(S_SEQ, 32'd63, 70, "seq_sat");
      step(70);
      rst_sequence = 1'b1; step(1); rst_sequence = 1'b0; inc_sequence_index = 1'b0;
      sb_push(S_SEQ, 32'd0, 0, "seq_rst_inc");
      inc_match_index = 1'b1; step(3); inc_match_index = 1'b0;
      sb_push(S_MATCH, 32'd3, 0, "match_3");
      rst_match = 1'b1; inc_match_index = 1'b1; step(1); rst_match = 1'b0; inc_match_index = 1'b0;
      sb_push(S_MATCH, 32'd0, 0, "match_rst_inc");

      // Score and best score
      inc_score = 1'b1; step(3); inc_score = 1'b0;
      sb_push(S_SCORE, 32'd3, 0, "score_3");
      update_score = 1'b1; step(1); update_score = 1'b0;
      sb_push(S_BEST, 32'd3, 0, "best_3");
      inc_score = 1'b1; step(2); inc_score = 1'b0;
      sb_push(S_SCORE, 32'd5, 0, "score_5");
      update_score = 1'b1; inc_score = 1'b1; step(1); update_score = 1'b0; inc_score = 1'b0;
      sb_push(S_BEST, 32'd5, 0, "best_upd_inc"); sb_push(S_SCORE, 32'd6, 0, "score_6");
      rst_score = 1'b1; inc_score = 1'b1; step(1); rst_score = 1'b0; inc_score = 1'b0;
      sb_push(S_SCORE, 32'd0, 0, "score_rst"); sb_push(S_BEST, 32'd5, 0, "best_after_rst");
      update_score = 1'b1; step(1); update_score = 1'b0;
      sb_push(S_BEST, 32'd5, 0, "best_keep");
      inc_score = 1'b1;
      sb_push(S_SCORE, 32'd255, 255, "score_255"); sb_push(S_SCORE, 32'd255, 260, "score_sat");
      step(260); inc_score = 1'b0;

      // Asynchronous reset in the middle of a display
      enable_led = 1'b1; step(1); enable_led = 1'b0;
      sb_push(S_BUSY, 32'd1, 0, "busy_pre_rst");
      step(3); rst_n = 1'b0; #1;
      sb_push(S_LEDS, 32'h0, 0, "rst_leds"); sb_push(S_BUSY, 32'd0, 0, "rst_busy");
      sb_push(S_SCORE, 32'd0, 0, "rst_score"); sb_push(S_BEST, 32'd0, 0, "rst_best");
      step(2); rst_n = 1'b1; step(2);

      for (int i = 0; i < 100 && sb_q.size() > 0; i++) step(1);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations never checked, required 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
